ycbcr_to_rgb: RTL and testbench

- AXI4-Stream video colour-space converter from YCbCr to RGB, the decode side of the RGB-to-YCbCr stage.
- Sits after the YCbCr transport or processing chain and ahead of the display or HDMI output path.
- 3-stage fixed-point pipeline with full valid/ready backpressure; tlast and tuser travel with the data.

---
 rtl/ycbcr_to_rgb_if.sv | 13 +
 rtl/ycbcr_to_rgb.sv | 179 +++++++++++++++++
 tb/tb_ycbcr_to_rgb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr_to_rgb_if.sv
// AXI4-Stream video beat bundle used on both sides of the YCbCr-to-RGB converter.
// The master drives data, valid and sideband. The slave drives ready.
`timescale 1ns/1ps
interface ycbcr_to_rgb_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/ycbcr_to_rgb.sv
// YCbCr to RGB colour-space converter: a 3-stage fixed-point pipeline with valid/ready backpressure.
// Optional macro YCBCR_TO_RGB_BYPASS_EN adds a per-beat bypass input that passes tdata through unconverted.
`timescale 1ns/1ps
module ycbcr_to_rgb #(
  parameter int CIN_OFFSET = 128,
  parameter int FRAC_BITS  = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef YCBCR_TO_RGB_BYPASS_EN
  input  logic bypass,
`endif
  ycbcr_to_rgb_if.slave  s_axis_video,
  ycbcr_to_rgb_if.master m_axis_video
);

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // Stage k loads when it is empty or when stage k+1 loads, so bubbles collapse.
  // Upstream ready is the stage-1 load term, forced low during reset.

  localparam logic signed [17:0] K_R_CR = 18'sd359;
  localparam logic signed [17:0] K_G_CB = 18'sd88;
  localparam logic signed [17:0] K_G_CR = 18'sd183;
  localparam logic signed [17:0] K_B_CB = 18'sd454;
  localparam logic signed [17:0] ROUND  = 18'(1 << (FRAC_BITS - 1));
  localparam logic        [8:0]  CIN    = 9'(CIN_OFFSET);

  logic load1, load2, load3;

  // Stage 1: luma and offset-removed chroma
  logic              v1, last1, user1;
  logic        [7:0] y1;
  logic signed [8:0] dcb1, dcr1;

  // Stage 2: rounded chroma contributions
  logic              v2, last2, user2;
  logic        [7:0] y2;
  logic signed [9:0] rr2, rg2, rb2;

  // Stage 3: saturated output
  logic              v3, last3, user3;
  logic       [23:0] rgb3;

`ifdef YCBCR_TO_RGB_BYPASS_EN
  logic        bp1, bp2;
  logic [23:0] raw1, raw2;
`endif

  logic signed [8:0]  dcb_n, dcr_n;
  logic signed [17:0] dcb18, dcr18;
  logic signed [9:0]  rr_n, rg_n, rb_n;
  logic signed [10:0] y11, r_sum, g_sum, b_sum;
  logic        [23:0] rgb_n;

  function automatic logic [7:0] sat8(input logic signed [10:0] v);
    if (v < 11'sd0)
      return 8'h00;
    else if (v > 11'sd255)
      return 8'hFF;
    else
      return 8'(v);
  endfunction

  always_comb begin
    load3 = !v3 || m_axis_video.tready;
    load2 = !v2 || load3;
    load1 = !v1 || load2;
  end

  assign s_axis_video.tready = load1 && !rst;

  always_comb begin
    dcb_n = $signed(s_axis_video.tdata[15:8] - CIN);
    dcr_n = $signed(s_axis_video.tdata[23:16] - CIN);
    if (s_axis_video.tdata[15:8] < CIN)
      dcb_n = -$signed({1'b0, CIN - s_axis_video.tdata[15:8]});
    if (s_axis_video.tdata[23:16] < CIN)
      dcr_n = -$signed({1'b0, CIN - s_axis_video.tdata[23:16]});
  end

  always_comb begin
    dcb18 = 18'(dcb1);
    dcr18 = 18'(dcr1);
    rr_n  = 10'((K_R_CR * dcr18 + ROUND) >>> FRAC_BITS);
    rg_n  = 10'((K_G_CB * dcb18 + K_G_CR * dcr18 + ROUND) >>> FRAC_BITS);
    rb_n  = 10'((K_B_CB * dcb18 + ROUND) >>> FRAC_BITS);
  end

  always_comb begin
    y11   = $signed({3'b000, y2});
    r_sum = y11 + 11'(rr2);
    g_sum = y11 - 11'(rg2);
    b_sum = y11 + 11'(rb2);
    rgb_n = {sat8(r_sum), sat8(b_sum), sat8(g_sum)};
`ifdef YCBCR_TO_RGB_BYPASS_EN
    if (bp2)
      rgb_n = raw2;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      user1 <= 1'b0;
      y1    <= 8'h00;
      dcb1  <= 9'sd0;
      dcr1  <= 9'sd0;
    end else if (load1) begin
      v1    <= s_axis_video.tvalid;
      last1 <= s_axis_video.tlast;
      user1 <= s_axis_video.tuser;
      y1    <= s_axis_video.tdata[7:0];
      dcb1  <= dcb_n;
      dcr1  <= dcr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      user2 <= 1'b0;
      y2    <= 8'h00;
      rr2   <= 10'sd0;
      rg2   <= 10'sd0;
      rb2   <= 10'sd0;
    end else if (load2) begin
      v2    <= v1;
      last2 <= last1;
      user2 <= user1;
      y2    <= y1;
      rr2   <= rr_n;
      rg2   <= rg_n;
      rb2   <= rb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3    <= 1'b0;
      last3 <= 1'b0;
      user3 <= 1'b0;
      rgb3  <= 24'h000000;
    end else if (load3) begin
      v3    <= v2;
      last3 <= last2;
      user3 <= user2;
      rgb3  <= rgb_n;
    end
  end

`ifdef YCBCR_TO_RGB_BYPASS_EN
  // The raw beat rides alongside the converted terms so a bypassed beat keeps the same latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp1  <= 1'b0;
      raw1 <= 24'h000000;
      bp2  <= 1'b0;
      raw2 <= 24'h000000;
    end else begin
      if (load1) begin
        bp1  <= bypass;
        raw1 <= s_axis_video.tdata;
      end
      if (load2) begin
        bp2  <= bp1;
        raw2 <= raw1;
      end
    end
  end
`endif

  assign m_axis_video.tdata  = rgb3;
  assign m_axis_video.tvalid = v3;
  assign m_axis_video.tlast  = last3;
  assign m_axis_video.tuser  = user3;

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Bench for ycbcr_to_rgb: directed corner beats plus a randomized stream scored against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_ycbcr_to_rgb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ycbcr_to_rgb_if s_if ();
  ycbcr_to_rgb_if m_if ();
  logic bypass_in = 1'b0;

  ycbcr_to_rgb dut (
    .clk          (clk),
    .rst          (rst),
`ifdef YCBCR_TO_RGB_BYPASS_EN
    .bypass       (bypass_in),
`endif
    .s_axis_video (s_if.slave),
    .m_axis_video (m_if.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
  bit check_lat = 1'b0;
  bit saw_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] clamp(input int v);
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return 8'(v);
  endfunction

  function automatic logic [25:0] model(input logic [23:0] d, input logic l, input logic u, input logic b);
    int y, dcb, dcr, r, g, bl;
    y   = int'(d[7:0]);
    dcb = int'(d[15:8]) - 128;
    dcr = int'(d[23:16]) - 128;
    r   = y + ((359 * dcr + 128) >>> 8);
    g   = y - ((88 * dcb + 183 * dcr + 128) >>> 8);
    bl  = y + ((454 * dcb + 128) >>> 8);
    if (b) return {l, u, d};
    return {l, u, clamp(r), clamp(bl), clamp(g)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [25:0] exp_q[$];
  int          t_q[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      t_q.delete();
    end else begin
      check("s_ready", s_if.tready, !(exp_q.size() == 3 && !m_if.tready));
      if (!s_if.tready) saw_stall = 1'b1;
      if (m_if.tvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          check("out_beat", {m_if.tlast, m_if.tuser, m_if.tdata}, exp_q[0]);
          if (m_if.tready) begin
            void'(exp_q.pop_front());
            if (check_lat) check("latency", cyc - t_q[0], 3);
            void'(t_q.pop_front());
          end
        end
      end
      if (s_if.tvalid && s_if.tready) begin
        exp_q.push_back(model(s_if.tdata, s_if.tlast, s_if.tuser, bypass_in));
        t_q.push_back(cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ($urandom_range(0, 3) != 0);
      default: m_if.tready = 1'b0;
    endcase
  end

  task automatic send(input logic [23:0] d, input logic l, input logic u, input logic b);
    bit acc;
    acc = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tuser  = u;
    bypass_in   = b;
    s_if.tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 0, 1);
    s_if.tvalid = 1'b0;
    s_if.tdata  = 24'($urandom);
    bypass_in   = 1'b0;
  endtask

  task automatic wait_out(output logic [23:0] d);
    bit seen;
    seen = 1'b0;
    d = 24'h0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (m_if.tvalid) begin
        d = m_if.tdata;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("out_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  logic [23:0] got;
  logic [25:0] want;

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 24'h0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_if.tvalid, 0);
    check("rst_m_data", m_if.tdata, 24'h000000);
    check("rst_m_side", {m_if.tlast, m_if.tuser}, 0);
    check("rst_s_ready", s_if.tready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // grey point, latency and single-cycle valid
    check_lat = 1'b1;
    send(24'h808080, 1'b0, 1'b1, 1'b0);
    wait_out(got);
    check("grey", got, 24'h808080);
    @(negedge clk);
    check("grey_one_cycle", m_if.tvalid, 0);

    send(24'hFF80FF, 1'b0, 1'b0, 1'b0);
    wait_out(got);
    check("upper_clamp", got, 24'hFFFFA4);
    send(24'h000000, 1'b0, 1'b0, 1'b0);
    wait_out(got);
    check("lower_clamp", got, 24'h000087);
    idle(3);
    check_lat = 1'b0;

    // backpressure: 10 beats, ready low for cycles 4-9
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send({16'h8080, 8'(8'h10 + i)}, i == 9, i == 0, 1'b0);
      end
      begin
        idle(4);
        ready_mode = 2;
        idle(6);
        ready_mode = 0;
      end
    join
    idle(8);
    check("bp_stall_seen", saw_stall, 1);
    check("bp_drained", exp_q.size(), 0);

    // reset with three beats in flight
    ready_mode = 2;
    idle(2);
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, i == 0, 1'b0);
    @(negedge clk);
    check("held_three", exp_q.size(), 3);
    @(posedge clk);
    #1 rst = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", m_if.tvalid, 0);
    idle(1);
    send(24'h10EF40, 1'b1, 1'b1, 1'b0);
    wait_out(got);
    want = model(24'h10EF40, 1'b1, 1'b1, 1'b0);
    check("after_rst", got, want[23:0]);
    idle(4);

`ifdef YCBCR_TO_RGB_BYPASS_EN
    check_lat = 1'b1;
    send(24'h12AB34, 1'b0, 1'b0, 1'b1);
    send(24'h808080, 1'b0, 1'b0, 1'b0);
    wait_out(got);
    check("bypass_raw", got, 24'h12AB34);
    wait_out(got);
    check("bypass_then_conv", got, 24'h808080);
    idle(4);
    check_lat = 1'b0;
`endif

    // randomized stream with random gaps and random backpressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
`ifdef YCBCR_TO_RGB_BYPASS_EN
      send(24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      send(24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
`endif
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    ready_mode = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
